avalon_accu_master: RTL and testbench
=====================================

# avalon_accu_master

Avalon-MM initiator that drives the near-memory-compute SRAM window: it turns word-count commands into Avalon write, accumulate-write or read transfers. It sits between an on-chip producer/consumer (accelerator or DMA front end) and the accumulating SRAM slave. Write data enters on a valid/ready stream and read data leaves on a valid-only stream. Accumulate traffic is tagged through address bit 63, and the block honours the slave's waitrequest stall.

## Interface
- ReadLatency, 1, fixed cycles from accepted read to valid AvalonReadData_i (1..4)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- CmdValid_i  in  1  command offered
- CmdReady_o  out  1  command accepted when CmdValid_i & CmdReady_o
- CmdOp_i  in  2  00 write, 01 accumulate, 10 read, 11 reserved
- CmdAddr_i  in  9  start word address
- CmdLen_i  in  10  word count, 0..512
- WrData_i  in  512  write/accumulate data word
- WrValid_i  in  1  write word offered
- WrReady_o  out  1  word consumed when WrValid_i & WrReady_o
- RdData_o  out  512  read data word
- RdValid_o  out  1  one-cycle qualifier; no backpressure
- Busy_o  out  1  command in progress
- Done_o  out  1  one-cycle completion pulse
- CmdErr_o  out  1  one-cycle pulse with Done_o for reserved op
- AvalonAddr_o  out  64  [63]=accumulate tag, [8:0]=word address, others 0
- AvalonRead_o / AvalonWrite_o  out  1 each  request strobes, never both high
- AvalonByteEnable_o  out  64  all ones while a request is high, else 0
- AvalonWriteData_o  out  512  write data
- AvalonLock_o  out  1  high for the whole of an accumulate command
- AvalonReadData_i  in  512  read data
- AvalonWaitReq_i  in  1  slave stall

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE: CmdReady_o=1. A command is latched on acceptance, including the address counter and a remaining count.
  - Op 00/01 go to WRITE.
  - Op 10 goes to READ.
  - Op 11 or CmdLen_i=0 goes to FINISH.
- WRITE: a one-entry registered request stage holds Avalon addr/write/data.
  - WrReady_o = ~stage_full | (AvalonWrite_o & ~AvalonWaitReq_i), gated by issued words < length.
  - A consumed word loads the stage with AvalonWrite_o=1, the current address and the data. The address counter then increments.
  - A transfer completes on AvalonWrite_o & ~AvalonWaitReq_i.
  - While AvalonWaitReq_i=1, addr/data/strobe/byteenable hold stable.
  - The FSM goes to FINISH on completion of the last word.
- Accumulate: AvalonAddr_o[63]=1 and AvalonLock_o=1 from the first request through the last completion.
- READ: AvalonRead_o is held with an incrementing address until every request is accepted (AvalonRead_o & ~AvalonWaitReq_i).
  - Each acceptance pushes a token into a ReadLatency-deep shift register.
  - A token exiting the register captures AvalonReadData_i into RdData_o and pulses RdValid_o the next cycle.
  - After the last acceptance the FSM goes to DRAIN and waits until the shift register is empty and the last RdValid_o has been issued, then goes to FINISH.
- FINISH: Done_o=1 for one cycle, with CmdErr_o if reserved, then IDLE.
- Address arithmetic is 9-bit modulo 512: 0x1FF+1 wraps to 0x000. Lengths above 512 are not supported; CmdLen_i[9] with nonzero low bits is treated as 512.
- Busy_o = state != IDLE.

## Timing
- Reset: all outputs 0, including CmdReady_o during the reset cycle. The shift register is cleared and the FSM is in IDLE.
- rst mid-operation: abort on the next edge. Strobes drop and in-flight read tokens are discarded, with no RdValid_o or Done_o.
- The first Avalon request appears no earlier than 1 cycle after command acceptance.
- Normal write throughput: 1 word/cycle with WrValid_i held high and AvalonWaitReq_i=0.
- Accumulate throughput: 1 word per 2 cycles, because the slave stalls each accumulate once.
- Read: RdValid_o for a request accepted at cycle T occurs at T+ReadLatency+1. Throughput is 1/cycle.
- Done_o occurs 1 cycle after the last write completion, or 1 cycle after the last RdValid_o.
- Len=0 or reserved op: Done_o occurs 1 cycle after acceptance, with no Avalon activity.
- A new command may be accepted the cycle after Done_o.

## Test plan
- Write, addr 0x010, len 4, data D0..D3, waitreq=0: AvalonWrite_o high 4 consecutive cycles at 0x010..0x013 with byteenable all ones. Done_o follows 1 cycle later.
- Accumulate, addr 0x005, len 2, slave model stalls 1 cycle per write: AvalonAddr_o = 0x8000_0000_0000_0005 then …0006, each held 2 cycles. AvalonLock_o stays high throughout and WrReady_o pulses twice.
- Read, addr 0x020, len 3, ReadLatency=1, memory holding A,B,C: RdValid_o pulses 3 consecutive cycles with A,B,C, then Done_o.
- Wrap: write at addr 0x1FE, len 4 produces addresses 0x1FE, 0x1FF, 0x000, 0x001.
- Len 0, then op 11: each produces Done_o 1 cycle after acceptance with no strobes, and the second also pulses CmdErr_o.
- rst asserted during the 2nd word of a 4-word accumulate: next cycle all strobes, Lock, Busy_o and RdValid_o are 0 and Done_o stays 0. A subsequent command then runs normally.

Source files
------------

// File: rtl/avalon_accu_master_if.sv
// rtl/avalon_accu_master_if.sv - Avalon-MM request/response bundle between the accumulating master and the SRAM window
interface avalon_accu_master_if;
    logic [63:0]  AvalonAddr_o;
    logic         AvalonRead_o;
    logic         AvalonWrite_o;
    logic [63:0]  AvalonByteEnable_o;
    logic [511:0] AvalonWriteData_o;
    logic         AvalonLock_o;
    logic [511:0] AvalonReadData_i;
    logic         AvalonWaitReq_i;

    modport master (
        output AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonByteEnable_o,
               AvalonWriteData_o, AvalonLock_o,
        input  AvalonReadData_i, AvalonWaitReq_i
    );

    modport slave (
        input  AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonByteEnable_o,
               AvalonWriteData_o, AvalonLock_o,
        output AvalonReadData_i, AvalonWaitReq_i
    );
endinterface

// File: rtl/avalon_accu_master.sv
// rtl/avalon_accu_master.sv - word-count command engine issuing Avalon write, accumulate-write and read bursts
module avalon_accu_master #(
    parameter int ReadLatency = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     CmdValid_i,
    output logic                     CmdReady_o,
    input  logic [1:0]               CmdOp_i,
    input  logic [8:0]               CmdAddr_i,
    input  logic [9:0]               CmdLen_i,
    input  logic [511:0]             WrData_i,
    input  logic                     WrValid_i,
    output logic                     WrReady_o,
    output logic [511:0]             RdData_o,
    output logic                     RdValid_o,
    output logic                     Busy_o,
    output logic                     Done_o,
    output logic                     CmdErr_o,
    avalon_accu_master_if.master     av
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [8:0]             addr_q, addr_d;
    logic [9:0]             len_q, len_d;
    logic [9:0]             issued_q, issued_d;
    logic [9:0]             cmpl_q, cmpl_d;
    logic                   acc_q, acc_d;
    logic                   err_q, err_d;
    logic                   stage_full_q, stage_full_d;
    logic [8:0]             stage_addr_q, stage_addr_d;
    logic [511:0]           stage_data_q, stage_data_d;
    logic [ReadLatency-1:0] tok_q, tok_d;
    logic [511:0]           rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;

    logic       cmd_ready, cmd_fire;
    logic       wr_ready, wr_take, wr_fire;
    logic       rd_req, rd_fire, tok_exit;
    logic [9:0] eff_len;

    always_comb begin
        cmd_ready = (state_q == S_IDLE) & ~rst;
        cmd_fire  = CmdValid_i & cmd_ready;
        // Lengths with bit 9 set saturate to a full 512-word window.
        eff_len   = CmdLen_i[9] ? 10'd512 : {1'b0, CmdLen_i[8:0]};
        wr_fire   = stage_full_q & ~av.AvalonWaitReq_i;
        wr_ready  = (state_q == S_WRITE) & (issued_q < len_q) &
                    (~stage_full_q | ~av.AvalonWaitReq_i);
        wr_take   = WrValid_i & wr_ready;
        rd_req    = (state_q == S_READ);
        rd_fire   = rd_req & ~av.AvalonWaitReq_i;
        tok_exit  = tok_q[ReadLatency-1];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        issued_d     = issued_q;
        cmpl_d       = cmpl_q;
        acc_d        = acc_q;
        err_d        = err_q;
        stage_full_d = wr_take | (stage_full_q & ~wr_fire);
        stage_addr_d = stage_addr_q;
        stage_data_d = stage_data_q;
        tok_d        = '0;
        tok_d[0]     = rd_fire;
        for (int i = 1; i < ReadLatency; i++) begin
            tok_d[i] = tok_q[i-1];
        end
        rd_valid_d   = tok_exit;
        rd_data_d    = tok_exit ? av.AvalonReadData_i : rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    addr_d   = CmdAddr_i;
                    len_d    = eff_len;
                    issued_d = '0;
                    cmpl_d   = '0;
                    acc_d    = (CmdOp_i == 2'b01);
                    err_d    = (CmdOp_i == 2'b11);
                    if (CmdOp_i == 2'b11 || eff_len == 10'd0) begin
                        state_d = S_FINISH;
                    end else if (CmdOp_i == 2'b10) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_take) begin
                    stage_addr_d = addr_q;
                    stage_data_d = WrData_i;
                    addr_d       = addr_q + 9'd1;
                    issued_d     = issued_q + 10'd1;
                end
                if (wr_fire) begin
                    cmpl_d = cmpl_q + 10'd1;
                    if (cmpl_q == len_q - 10'd1) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_READ: begin
                if (rd_fire) begin
                    addr_d   = addr_q + 9'd1;
                    issued_d = issued_q + 10'd1;
                    if (issued_q == len_q - 10'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Empty pipe plus a just-issued RdValid means the last word is out.
                if (tok_q == '0 && rd_valid_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            cmpl_q       <= '0;
            acc_q        <= 1'b0;
            err_q        <= 1'b0;
            stage_full_q <= 1'b0;
            stage_addr_q <= '0;
            stage_data_q <= '0;
            tok_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            cmpl_q       <= cmpl_d;
            acc_q        <= acc_d;
            err_q        <= err_d;
            stage_full_q <= stage_full_d;
            stage_addr_q <= stage_addr_d;
            stage_data_q <= stage_data_d;
            tok_q        <= tok_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    always_comb begin
        CmdReady_o            = cmd_ready;
        WrReady_o             = wr_ready;
        RdData_o              = rd_data_q;
        RdValid_o             = rd_valid_q;
        Busy_o                = (state_q != S_IDLE);
        Done_o                = (state_q == S_FINISH);
        CmdErr_o              = (state_q == S_FINISH) & err_q;
        av.AvalonWrite_o      = stage_full_q;
        av.AvalonRead_o       = rd_req;
        av.AvalonWriteData_o  = stage_data_q;
        av.AvalonByteEnable_o = (stage_full_q | rd_req) ? {64{1'b1}} : 64'd0;
        // Lock spans the first request of an accumulate through its last completion.
        av.AvalonLock_o       = acc_q & (state_q == S_WRITE) & (issued_q != 10'd0);
        if (stage_full_q) begin
            av.AvalonAddr_o = {acc_q, 54'd0, stage_addr_q};
        end else if (rd_req) begin
            av.AvalonAddr_o = {55'd0, addr_q};
        end else begin
            av.AvalonAddr_o = 64'd0;
        end
    end
endmodule

// File: tb/tb_avalon_accu_master.sv
// tb/tb_avalon_accu_master.sv - scoreboard bench for avalon_accu_master with a stalling SRAM slave model
module tb_avalon_accu_master;
    localparam int RL = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         CmdValid_i = 1'b0;
    logic         CmdReady_o;
    logic [1:0]   CmdOp_i = '0;
    logic [8:0]   CmdAddr_i = '0;
    logic [9:0]   CmdLen_i = '0;
    logic [511:0] WrData_i = '0;
    logic         WrValid_i = 1'b0;
    logic         WrReady_o;
    logic [511:0] RdData_o;
    logic         RdValid_o;
    logic         Busy_o;
    logic         Done_o;
    logic         CmdErr_o;

    avalon_accu_master_if bus();

    avalon_accu_master #(.ReadLatency(RL)) dut (
        .clk        (clk),
        .rst        (rst),
        .CmdValid_i (CmdValid_i),
        .CmdReady_o (CmdReady_o),
        .CmdOp_i    (CmdOp_i),
        .CmdAddr_i  (CmdAddr_i),
        .CmdLen_i   (CmdLen_i),
        .WrData_i   (WrData_i),
        .WrValid_i  (WrValid_i),
        .WrReady_o  (WrReady_o),
        .RdData_o   (RdData_o),
        .RdValid_o  (RdValid_o),
        .Busy_o     (Busy_o),
        .Done_o     (Done_o),
        .CmdErr_o   (CmdErr_o),
        .av         (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   kind;
        logic [31:0]  rel;
        logic [63:0]  addr;
        logic [511:0] data;
        logic         err;
    } ev_t;

    ev_t          sb[$];
    logic [511:0] wr_words[$];
    logic [511:0] mem [0:511];
    logic [511:0] rpipe [RL];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           t_acc = 0;
    int           wr_take_cnt = 0;
    int           lock_cnt = 0;
    logic         stall_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input logic [1:0] kind, input int rel, input logic [63:0] addr,
                           input logic [511:0] data, input logic err);
        ev_t e;
        e.kind = kind; e.rel = rel; e.addr = addr; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check_ev(input ev_t got);
        ev_t exp;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event kind=%0d rel=%0d addr=%h data=%h", got.kind, got.rel,
                     got.addr, got.data[63:0]);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                n_err++;
                $display("FAIL event got kind=%0d rel=%0d addr=%h data=%h err=%b exp kind=%0d rel=%0d addr=%h data=%h err=%b",
                         got.kind, got.rel, got.addr, got.data[63:0], got.err,
                         exp.kind, exp.rel, exp.addr, exp.data[63:0], exp.err);
            end
        end
    endtask

    // Monitor: every observable output event is checked against the scoreboard.
    initial begin
        ev_t g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.AvalonWrite_o | bus.AvalonRead_o) begin
                    n_vec++;
                    if ((bus.AvalonWrite_o & bus.AvalonRead_o) || bus.AvalonByteEnable_o !== {64{1'b1}} ||
                        bus.AvalonLock_o !== (bus.AvalonWrite_o & bus.AvalonAddr_o[63])) begin
                        n_err++;
                        $display("FAIL proto wr=%b rd=%b be=%h lock=%b addr=%h", bus.AvalonWrite_o,
                                 bus.AvalonRead_o, bus.AvalonByteEnable_o, bus.AvalonLock_o, bus.AvalonAddr_o);
                    end
                end
                if (bus.AvalonLock_o) lock_cnt++;
                if (bus.AvalonWrite_o & ~bus.AvalonWaitReq_i) begin
                    g.kind = 2'd0; g.rel = cyc - t_acc; g.addr = bus.AvalonAddr_o;
                    g.data = bus.AvalonWriteData_o; g.err = 1'b0;
                    check_ev(g);
                end
                if (RdValid_o) begin
                    g.kind = 2'd1; g.rel = cyc - t_acc; g.addr = '0; g.data = RdData_o; g.err = 1'b0;
                    check_ev(g);
                end
                if (Done_o) begin
                    g.kind = 2'd2; g.rel = cyc - t_acc; g.addr = '0; g.data = '0; g.err = CmdErr_o;
                    check_ev(g);
                end else if (CmdErr_o) begin
                    n_vec++; n_err++;
                    $display("FAIL cmderr_without_done got 1 exp 0");
                end
            end
        end
    end

    // Write-data source: presents queued words, pops on handshake.
    initial begin
        logic take;
        forever begin
            @(negedge clk);
            take = WrValid_i & WrReady_o;
            @(posedge clk);
            #1;
            if (take && !rst && wr_words.size() > 0) begin
                void'(wr_words.pop_front());
                wr_take_cnt++;
            end
            WrValid_i = (wr_words.size() > 0);
            WrData_i  = (wr_words.size() > 0) ? wr_words[0] : '0;
        end
    end

    // Slave: one stall per accumulate request when enabled; fixed-latency read return.
    initial begin
        logic       rfire;
        logic [8:0] raddr;
        logic       stalled;
        stalled = 1'b0;
        bus.AvalonWaitReq_i  = 1'b0;
        bus.AvalonReadData_i = '0;
        for (int i = 0; i < RL; i++) rpipe[i] = '0;
        forever begin
            @(negedge clk);
            rfire = bus.AvalonRead_o & ~bus.AvalonWaitReq_i;
            raddr = bus.AvalonAddr_o[8:0];
            @(posedge clk);
            #1;
            if (stall_en && bus.AvalonWrite_o && bus.AvalonAddr_o[63] && !stalled) begin
                bus.AvalonWaitReq_i = 1'b1;
                stalled = 1'b1;
            end else begin
                bus.AvalonWaitReq_i = 1'b0;
                stalled = 1'b0;
            end
            for (int i = RL - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
            rpipe[0] = rfire ? mem[raddr] : '0;
            bus.AvalonReadData_i = rpipe[RL-1];
        end
    end

    task automatic issue(input logic [1:0] op, input logic [8:0] addr, input logic [9:0] len);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        CmdValid_i = 1'b1; CmdOp_i = op; CmdAddr_i = addr; CmdLen_i = len;
        for (int i = 0; i < 20; i++) begin
            if (CmdReady_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL cmd_accept_timeout got ready=0 exp 1");
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
        CmdValid_i = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (Done_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout got no Done_o exp Done_o");
        end
    endtask

    // step = cycles per word (1 plain, 2 with one stall per accumulate request).
    task automatic do_write(input logic [1:0] op, input logic [8:0] addr, input int len, input int step);
        logic [511:0] w;
        logic [8:0]   a;
        for (int i = 0; i < len; i++) begin
            w = {16{32'h5A00_0000 + {21'd0, addr, 2'd0} + 32'(i)}};
            a = addr + 9'(i);
            wr_words.push_back(w);
            push_ev(2'd0, step * (i + 1), {(op == 2'b01), 54'd0, a}, w, 1'b0);
        end
        push_ev(2'd2, step * len + 1, '0, '0, 1'b0);
        issue(op, addr, 10'(len));
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({CmdReady_o, Busy_o, Done_o, CmdErr_o, RdValid_o, WrReady_o, bus.AvalonRead_o,
             bus.AvalonWrite_o, bus.AvalonLock_o} !== 9'd0 || bus.AvalonAddr_o !== 64'd0 ||
            bus.AvalonByteEnable_o !== 64'd0 || RdData_o !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got ready=%b busy=%b done=%b wr=%b rd=%b exp all 0",
                     CmdReady_o, Busy_o, Done_o, bus.AvalonWrite_o, bus.AvalonRead_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        do_write(2'b00, 9'h010, 4, 1);

        stall_en = 1'b1;
        wr_take_cnt = 0;
        lock_cnt = 0;
        do_write(2'b01, 9'h005, 2, 2);
        stall_en = 1'b0;
        n_vec++;
        if (wr_take_cnt != 2 || lock_cnt != 4) begin
            n_err++;
            $display("FAIL acc_ready_lock got takes=%0d lock_cycles=%0d exp 2 and 4", wr_take_cnt, lock_cnt);
        end

        mem[9'h020] = {8{64'hAAAA_0000_0000_0001}};
        mem[9'h021] = {8{64'hBBBB_0000_0000_0002}};
        mem[9'h022] = {8{64'hCCCC_0000_0000_0003}};
        push_ev(2'd1, 2, '0, mem[9'h020], 1'b0);
        push_ev(2'd1, 3, '0, mem[9'h021], 1'b0);
        push_ev(2'd1, 4, '0, mem[9'h022], 1'b0);
        push_ev(2'd2, 5, '0, '0, 1'b0);
        issue(2'b10, 9'h020, 10'd3);
        wait_done();

        do_write(2'b00, 9'h1FE, 4, 1);

        push_ev(2'd2, 0, '0, '0, 1'b0);
        issue(2'b00, 9'h033, 10'd0);
        wait_done();
        push_ev(2'd2, 0, '0, '0, 1'b1);
        issue(2'b11, 9'h040, 10'd5);
        wait_done();

        // Abort a 4-word accumulate while its second word is stalled.
        stall_en = 1'b1;
        for (int i = 0; i < 4; i++) wr_words.push_back({16{32'hE000_0000 + 32'(i)}});
        push_ev(2'd0, 2, {1'b1, 54'd0, 9'h100}, {16{32'hE000_0000}}, 1'b0);
        issue(2'b01, 9'h100, 10'd4);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        stall_en = 1'b0;
        wr_words.delete();
        @(negedge clk);
        n_vec++;
        if ({bus.AvalonWrite_o, bus.AvalonRead_o, bus.AvalonLock_o, Busy_o, RdValid_o, Done_o} !== 6'd0) begin
            n_err++;
            $display("FAIL abort_outputs got wr=%b rd=%b lock=%b busy=%b rdv=%b done=%b exp all 0",
                     bus.AvalonWrite_o, bus.AvalonRead_o, bus.AvalonLock_o, Busy_o, RdValid_o, Done_o);
        end
        repeat (6) @(negedge clk);

        do_write(2'b00, 9'h0AA, 2, 1);

        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got %0d pending exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
